// File: rtl/slow_mem_pkg.sv
// ============================================================================
// Module   : slow_mem_pkg
// Brief    : Shared line geometry, counter width and FSM state encoding for
//            the slow_mem_responder line memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package slow_mem_pkg;

    localparam int LINE_W      = 128;
    localparam int LINE_ADDR_W = 28;
    localparam int LATENCY_MAX = 255;
    localparam int CNT_W       = $clog2(LATENCY_MAX + 1);

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] IDLE = 2'd0;
    localparam logic [STATE_W-1:0] BUSY = 2'd1;
    localparam logic [STATE_W-1:0] DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/slow_mem_array.sv
// ============================================================================
// Module   : slow_mem_array
// Brief    : Single-port 2^ADDR_W x LINE_W line store, synchronous write,
//            combinational read. Contents are not reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module slow_mem_array
    import slow_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_idx,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] o_rdata
);

    logic [LINE_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

`default_nettype wire

// File: rtl/slow_mem_responder.sv
// ============================================================================
// Module   : slow_mem_responder
// Brief    : Fixed-latency line-granular backing memory behind a cache port.
//            Optional protocol checker enabled by SLOW_MEM_PROTO_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module slow_mem_responder
    import slow_mem_pkg::*;
#(
    parameter int LATENCY = 8,
    parameter int ADDR_W  = 10
) (
    input  logic                   clk,
    input  logic                   proc_reset,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [LINE_ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0]      mem_wdata,
    output logic [LINE_W-1:0]      mem_rdata,
    output logic                   mem_ready,
    output logic                   proto_err
);

    localparam logic [CNT_W-1:0] c_lat_m1 = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);

    logic [STATE_W-1:0] r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_op_write;
    logic [ADDR_W-1:0]  r_idx;
    logic [LINE_W-1:0]  r_wdata;
    logic [LINE_W-1:0]  r_rdata_hold;

    logic               w_req;
    logic               w_arr_we;
    logic [LINE_W-1:0]  w_arr_rdata;
    logic               w_unused_addr;

    assign w_req         = mem_read | mem_write;
    assign w_unused_addr = ^mem_addr;

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_rdata_hold <= '0;
            r_op_write   <= 1'b0;
            r_idx        <= '0;
            r_wdata      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_op_write <= mem_write;
                        r_idx      <= mem_addr[ADDR_W-1:0];
                        r_wdata    <= mem_wdata;
                        r_cnt      <= c_lat_m1;
                        r_state    <= (LATENCY == 1) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    // Leaving on the count that reaches zero lands DONE exactly LATENCY cycles after acceptance.
                    r_cnt <= r_cnt - c_one;
                    if (r_cnt <= c_one) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (!r_op_write) begin
                        r_rdata_hold <= w_arr_rdata;
                    end
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_arr_we  = (r_state == DONE) && r_op_write && !proc_reset;
    assign mem_ready = (r_state == DONE);
    assign mem_rdata = ((r_state == DONE) && !r_op_write) ? w_arr_rdata : r_rdata_hold;

    slow_mem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_arr_we),
        .i_idx   (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_arr_rdata)
    );

`ifdef SLOW_MEM_PROTO_CHECK_EN
    logic [LINE_ADDR_W-1:0] r_addr_full;
    logic                   r_proto_err;
    logic                   w_viol;

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_addr_full <= '0;
        end else if ((r_state == IDLE) && w_req) begin
            r_addr_full <= mem_addr;
        end
    end

    assign w_viol = (mem_read & mem_write) ||
                    ((r_state == BUSY) &&
                     (!w_req || (mem_addr != r_addr_full) || (mem_write != r_op_write)));

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_proto_err <= 1'b0;
        end else if (w_viol) begin
            r_proto_err <= 1'b1;
        end
    end

    assign proto_err = r_proto_err;
`else
    assign proto_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_slow_mem_responder.sv
// ============================================================================
// Module   : tb_slow_mem_responder
// Brief    : Directed self-checking bench for slow_mem_responder (LATENCY 8
//            and LATENCY 1 instances); honours SLOW_MEM_PROTO_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slow_mem_responder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rd0 = 1'b0, wr0 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
    logic [27:0]  addr0 = '0, addr1 = '0;
    logic [127:0] wd0 = '0, wd1 = '0;
    logic [127:0] rdata0, rdata1;
    logic         ready0, ready1, perr0, perr1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    slow_mem_responder #(.LATENCY(8), .ADDR_W(10)) dut (
        .clk(clk), .proc_reset(rst), .mem_read(rd0), .mem_write(wr0),
        .mem_addr(addr0), .mem_wdata(wd0), .mem_rdata(rdata0),
        .mem_ready(ready0), .proto_err(perr0)
    );

    slow_mem_responder #(.LATENCY(1), .ADDR_W(10)) dut1 (
        .clk(clk), .proc_reset(rst), .mem_read(rd1), .mem_write(wr1),
        .mem_addr(addr1), .mem_wdata(wd1), .mem_rdata(rdata1),
        .mem_ready(ready1), .proto_err(perr1)
    );

    // Raises a request, waits (bounded) for ready, then drops it the cycle after.
    task automatic req(input bit sel, input bit wr, input logic [27:0] a,
                       input logic [127:0] d, output int lat, output int rcyc,
                       output logic [127:0] rd);
        int  start;
        bit  seen;
        start = cyc;
        seen  = 1'b0;
        rcyc  = -1;
        lat   = -1;
        rd    = '0;
        if (sel) begin wr1 = wr; rd1 = !wr; addr1 = a; wd1 = d; end
        else     begin wr0 = wr; rd0 = !wr; addr0 = a; wd0 = d; end
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk); #1;
            if (sel ? ready1 : ready0) begin
                seen = 1'b1;
                rcyc = cyc;
                lat  = cyc - start;
                rd   = sel ? rdata1 : rdata0;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL req_timeout sel=%0d addr=%h got no ready within 40 cycles", sel, a);
        end
        @(posedge clk); #1;
        if (sel) begin wr1 = 0; rd1 = 0; end else begin wr0 = 0; rd0 = 0; end
        checks++;
        if ((sel ? ready1 : ready0) !== 1'b0) begin
            failures++;
            $display("FAIL ready_width sel=%0d got ready=%b exp 0 after pulse", sel, sel ? ready1 : ready0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ready0 !== 1'b0) begin failures++; $display("FAIL rst_ready0 got=%b exp=0", ready0); end
        checks++; if (rdata0 !== '0) begin failures++; $display("FAIL rst_rdata0 got=%h exp=0", rdata0); end
        checks++; if (perr0 !== 1'b0) begin failures++; $display("FAIL rst_perr0 got=%b exp=0", perr0); end
        checks++; if (ready1 !== 1'b0) begin failures++; $display("FAIL rst_ready1 got=%b exp=0", ready1); end
        checks++; if (rdata1 !== '0) begin failures++; $display("FAIL rst_rdata1 got=%h exp=0", rdata1); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [127:0] d, rd;
        int lat, rc;
        d = 128'hDEADBEEF_00000000_00000000_00000001;
        req(0, 1, 28'h0000010, d, lat, rc, rd);
        checks++; if (lat !== 8) begin failures++; $display("FAIL wr_latency got=%0d exp=8", lat); end
        req(0, 0, 28'h0000010, '0, lat, rc, rd);
        checks++; if (lat !== 8) begin failures++; $display("FAIL rd_latency got=%0d exp=8", lat); end
        checks++; if (rd !== d) begin failures++; $display("FAIL rd_data got=%h exp=%h", rd, d); end
        checks++; if (rdata0 !== d) begin failures++; $display("FAIL rdata_hold got=%h exp=%h", rdata0, d); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] p, x, rd;
        int lat, rca, rcb;
        p = 128'h99999999_88888888_77777777_66666666;
        x = 128'h55555555_44444444_33333333_22222222;
        req(0, 1, 28'h9, p, lat, rca, rd);
        req(0, 1, 28'h5, x, lat, rca, rd);
        req(0, 0, 28'h9, '0, lat, rcb, rd);
        checks++; if (rcb - rca !== 9) begin failures++; $display("FAIL b2b_spacing got=%0d exp=9", rcb - rca); end
        checks++; if (rd !== p) begin failures++; $display("FAIL b2b_alloc_data got=%h exp=%h", rd, p); end
        req(0, 0, 28'h5, '0, lat, rcb, rd);
        checks++; if (rd !== x) begin failures++; $display("FAIL b2b_wb_data got=%h exp=%h", rd, x); end
    endtask

    task automatic test_alias();
        logic [127:0] a, rd;
        int lat, rc;
        a = 128'hA11A5A11_00000401_CAFEF00D_12345678;
        req(0, 1, 28'h0000401, a, lat, rc, rd);
        req(0, 0, 28'h0000001, '0, lat, rc, rd);
        checks++; if (rd !== a) begin failures++; $display("FAIL alias_data got=%h exp=%h", rd, a); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] old_d, rd;
        int  lat, rc;
        bit  any_ready;
        old_d = 128'h0000_0007_0000_0007_0000_0007_0000_0007;
        req(0, 1, 28'h7, old_d, lat, rc, rd);
        any_ready = 1'b0;
        wr0 = 1; rd0 = 0; addr0 = 28'h7; wd0 = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
        repeat (3) begin @(posedge clk); #1; if (ready0) any_ready = 1'b1; end
        rst = 1'b1; wr0 = 0;
        repeat (2) begin @(posedge clk); #1; if (ready0) any_ready = 1'b1; end
        rst = 1'b0;
        repeat (12) begin @(posedge clk); #1; if (ready0) any_ready = 1'b1; end
        checks++; if (any_ready !== 1'b0) begin failures++; $display("FAIL rstmid_ready got=1 exp=0"); end
        req(0, 0, 28'h7, '0, lat, rc, rd);
        checks++; if (lat !== 8) begin failures++; $display("FAIL rstmid_latency got=%0d exp=8", lat); end
        checks++; if (rd !== old_d) begin failures++; $display("FAIL rstmid_data got=%h exp=%h", rd, old_d); end
    endtask

    task automatic test_latency1();
        logic [127:0] q, r, rd;
        int lat, rca, rcb;
        q = 128'h31313131_31313131_31313131_31313131;
        r = 128'h42424242_42424242_42424242_42424242;
        req(1, 1, 28'h3, q, lat, rca, rd);
        checks++; if (lat !== 1) begin failures++; $display("FAIL l1_wr_latency got=%0d exp=1", lat); end
        req(1, 1, 28'h4, r, lat, rca, rd);
        req(1, 0, 28'h3, '0, lat, rca, rd);
        checks++; if (lat !== 1) begin failures++; $display("FAIL l1_rd_latency got=%0d exp=1", lat); end
        checks++; if (rd !== q) begin failures++; $display("FAIL l1_rd_data3 got=%h exp=%h", rd, q); end
        req(1, 0, 28'h4, '0, lat, rcb, rd);
        checks++; if (rcb - rca !== 2) begin failures++; $display("FAIL l1_spacing got=%0d exp=2", rcb - rca); end
        checks++; if (rd !== r) begin failures++; $display("FAIL l1_rd_data4 got=%h exp=%h", rd, r); end
    endtask

    task automatic test_proto();
`ifdef SLOW_MEM_PROTO_CHECK_EN
        logic [127:0] w, rd;
        int  start, lat, rc;
        bit  seen;
        w = 128'h0F0F0F0F_F0F0F0F0_0F0F0F0F_F0F0F0F0;
        checks++; if (perr0 !== 1'b0) begin failures++; $display("FAIL proto_clean got=%b exp=0", perr0); end
        start = cyc; seen = 1'b0; lat = -1;
        wr0 = 1; rd0 = 1; addr0 = 28'h20; wd0 = w;
        @(posedge clk); #1;
        checks++; if (perr0 !== 1'b1) begin failures++; $display("FAIL proto_set got=%b exp=1", perr0); end
        for (int k = 0; k < 40 && !seen; k++) begin
            if (ready0) begin seen = 1'b1; lat = cyc - start; end
            else begin @(posedge clk); #1; end
        end
        checks++; if (lat !== 8) begin failures++; $display("FAIL proto_latency got=%0d exp=8", lat); end
        @(posedge clk); #1;
        wr0 = 0; rd0 = 0;
        checks++; if (perr0 !== 1'b1) begin failures++; $display("FAIL proto_sticky got=%b exp=1", perr0); end
        req(0, 0, 28'h20, '0, lat, rc, rd);
        checks++; if (rd !== w) begin failures++; $display("FAIL proto_write_wins got=%h exp=%h", rd, w); end
        checks++; if (perr1 !== 1'b0) begin failures++; $display("FAIL proto_inst1 got=%b exp=0", perr1); end
`else
        checks++; if (perr0 !== 1'b0) begin failures++; $display("FAIL proto_tied0 got=%b exp=0", perr0); end
        checks++; if (perr1 !== 1'b0) begin failures++; $display("FAIL proto_tied1 got=%b exp=0", perr1); end
`endif
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_alias();
        test_reset_mid();
        test_latency1();
        test_proto();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/slow_mem_responder.md
# slow_mem_responder

Line-granular backing-memory responder on the far side of the `cache` memory port. It answers `mem_read`/`mem_write` requests on 128-bit lines with a fixed, parameterised latency and pulses `mem_ready` when the request completes. Two instances sit beside `CHIP`: one behind `D_cache` and one behind `I_cache`. The block replaces the behavioural slow-memory model with synthesizable RTL.

## Interface
Parameters:
- `LATENCY`, 8: cycles from request acceptance to `mem_ready`; legal range is 1 to 255.
- `ADDR_W`, 10: number of low line-address bits used for indexing; depth is 2^ADDR_W lines.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `proc_reset`  in  1  synchronous, active-high reset; at `CHIP` level it is driven by `~rst_n`, as for the caches.
- `mem_read`  in  1  line read request; held by the cache until `mem_ready`.
- `mem_write`  in  1  line write request; held by the cache until `mem_ready`.
- `mem_addr`  in  28  line address, `[31:4]`.
- `mem_wdata`  in  128  write line.
- `mem_rdata`  out  128  read line; valid in the `mem_ready` cycle of a read.
- `mem_ready`  out  1  one-cycle completion pulse.
- `proto_err`  out  1  sticky protocol-violation flag; see Configuration.

## Operation
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - If `mem_write` or `mem_read` is high, latch the op, `mem_addr[ADDR_W-1:0]` and `mem_wdata`, load the counter with `LATENCY-1`, and go to BUSY.
  - If `LATENCY==1`, go directly to DONE instead.
  - Write has priority when both requests are high.
- BUSY:
  - Decrement the counter. At zero, go to DONE.
  - Inputs are ignored while in BUSY; the latched copy is authoritative.
- DONE:
  - Assert `mem_ready` for exactly one cycle, then return to IDLE.
  - For a write, the array is updated at the clock edge that ends DONE.
  - For a read, `mem_rdata` shows `array[idx]` in the DONE cycle.
- Address aliasing: `mem_addr[27:ADDR_W]` is ignored, so line addresses alias modulo 2^ADDR_W.
- Back-to-back requests: the cache changes or drops its request in the cycle after `mem_ready`. A request seen in IDLE immediately after DONE is accepted as new. This is the dirty-writeback-then-allocate sequence: write, ready, read.
- Read-after-write to the same line returns the new data.
- `mem_rdata` holds its last value outside DONE.

## Timing
- A request first seen high in IDLE at cycle T gets `mem_ready` high during cycle T+LATENCY only.
- The next request can be accepted at T+LATENCY+1.
- Throughput is one line per LATENCY+1 cycles.
- Reset values:
  - state is IDLE
  - counter is 0
  - `mem_ready` is 0
  - `mem_rdata` is all zeros
  - `proto_err` is 0
- Array contents are not reset.
- Reset mid-operation aborts the request: no array write occurs and no `mem_ready` is issued. The FSM is in IDLE on the first cycle after `proc_reset` falls.
- `mem_ready` is a registered output (it is the DONE state decode), with no combinational path from the inputs.

## Configuration
- Macro: `SLOW_MEM_PROTO_CHECK_EN`.
- When defined, `proto_err` is set and stays set until reset on any of these:
  - `mem_read` and `mem_write` both high in any cycle;
  - a request dropped during BUSY;
  - `mem_addr` changing during BUSY;
  - the op type changing during BUSY.
- When undefined, `proto_err` is tied to 0 and no checker logic is built.

## Structure
- Shared package `slow_mem_pkg` holds:
  - the state encoding (IDLE, BUSY, DONE);
  - `LINE_W=128`;
  - `LINE_ADDR_W=28`;
  - the counter width, derived from the `LATENCY` maximum of 255, i.e. 8 bits.
- One sub-module, `slow_mem_array`: a single-port 2^ADDR_W x 128 storage with synchronous write and combinational read. It is indexed only by the latched address.
- The FSM, counter and checker live in the top module.

## Test plan
- Write then read: write line 0x0000010 with data `128'hDEADBEEF_...0001`, then read line 0x0000010. Each `mem_ready` arrives exactly 8 cycles after the request, and the read returns the written data.
- Writeback then allocate: a write to line 0x5 followed, in the cycle after its ready, by a read of line 0x9. Two ready pulses appear, 9 cycles apart, and the read returns the pre-loaded line 0x9.
- Aliasing with `ADDR_W=10`: write line 0x00401, then read line 0x00001. The read returns the same data.
- Reset mid-request: assert reset 3 cycles into a write to line 0x7. No ready pulse occurs and line 0x7 keeps its old value. A read issued after reset gets ready 8 cycles later.
- `LATENCY=1`: a read request gets `mem_ready` in the next cycle, and consecutive reads complete every 2 cycles.
- Build with `SLOW_MEM_PROTO_CHECK_EN`: raise `mem_read` and `mem_write` together. `proto_err` goes to 1 on the next cycle, stays at 1, and the write is the one performed.
